// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, data width and bit-timing helper.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output; a push into a full FIFO is dropped
// unless a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    drop     = push && !do_push;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth lets the pointers wrap by plain overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  assign head_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises the line, samples each bit at its midpoint and queues
// completed bytes in a FIFO presented to the CPU bus as valid/ready.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              rx_meta_q, rx_meta_d;
  logic              rx_s_q, rx_s_d;
  logic              push;
  logic [DATA_W-1:0] head_data;
  logic              fifo_full, fifo_empty, fifo_drop;

  always_comb begin
    rx_meta_d = uart_rx;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // A start bit that is high again at its midpoint was a glitch.
        if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        // Hold off until the line is released so a stuck-low line yields one error only.
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift_d),
    .pop       (rx_ready),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign rx_valid = !fifo_empty;
  assign rx_data  = rx_valid ? head_data : '0;
  assign overrun  = fifo_drop;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: builds a line waveform, decodes it at the bit midpoints into
// expected FIFO pushes/errors, and compares the DUT against a queue model every cycle.
module tb_uart_receiver;

  localparam int C     = 10;
  localparam int H     = C / 2;
  localparam int DEPTH = 4;
  localparam int N     = 8192;
  localparam int PAD   = 110;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  always #5 clk = ~clk;

  uart_receiver #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  bit         line    [N];
  bit         rdy     [N];
  int         ev_kind [N];   // 0 none, 1 push, 2 framing error, at that clock edge
  logic [7:0] ev_byte [N];
  bit         busy_a  [N];   // FSM expected busy after that edge
  int         wp;
  logic [7:0] q[$];
  logic [7:0] popped[$];
  int         n_chk = 0, n_fail = 0;
  int         n_ovr, n_ferr, n_busy, first_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic seg_clear();
    for (int i = 0; i < N; i++) begin
      line[i] = 1'b1; rdy[i] = 1'b0; ev_kind[i] = 0; ev_byte[i] = '0; busy_a[i] = 1'b0;
    end
    wp = 0; popped.delete();
    n_ovr = 0; n_ferr = 0; n_busy = 0; first_valid = -1;
  endtask

  task automatic add_level(input bit v, input int n);
    for (int i = 0; i < n; i++) begin line[wp] = v; wp++; end
  endtask

  task automatic add_frame(input logic [7:0] b, input bit stop);
    add_level(1'b0, C);
    for (int k = 0; k < 8; k++) add_level(b[k], C);
    add_level(stop, C);
  endtask

  task automatic mark_busy(input int from, input int upto);
    for (int n = from; n < upto && n < N; n++) busy_a[n] = 1'b1;
  endtask

  // Line index n is sampled by the DUT at edge n; decisions see it two edges later.
  task automatic decode(input int len);
    int s, t, h, d;
    logic [7:0] b;
    s = 0;
    while (1) begin
      t = s;
      while (t < len && line[t]) t++;
      if (t >= len) break;
      if (line[t+H]) begin
        mark_busy(t + 2, t + 2 + H);
        s = t + H + 1;
        continue;
      end
      d = t + 2 + H + 9 * C;
      if (line[t+H+9*C]) begin
        for (int k = 0; k < 8; k++) b[k] = line[t+H+C*(k+1)];
        ev_kind[d] = 1; ev_byte[d] = b;
        mark_busy(t + 2, d);
        s = t + H + 9 * C + 1;
      end else begin
        ev_kind[d] = 2;
        h = t + H + 9 * C + 1;
        while (!line[h]) h++;
        mark_busy(t + 2, h + 2);
        s = h + 1;
      end
    end
  endtask

  task automatic run(input int len);
    bit pop_ok, exp_ovr;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      uart_rx = line[i]; rx_ready = rdy[i];
      #1;
      pop_ok  = rdy[i] && (q.size() > 0);
      exp_ovr = (ev_kind[i] == 1) && (q.size() == DEPTH) && !pop_ok;
      check("rx_valid", rx_valid, q.size() > 0);
      if (q.size() > 0) check("rx_data", rx_data, q[0]);
      check("frame_err", frame_err, ev_kind[i] == 2);
      check("overrun", overrun, exp_ovr);
      check("busy", busy, (i > 0) ? busy_a[i-1] : 1'b0);
      if (rx_valid && first_valid < 0) first_valid = i;
      if (overrun)   n_ovr++;
      if (frame_err) n_ferr++;
      if (busy)      n_busy++;
      if (rx_valid && rx_ready) popped.push_back(rx_data);
      if (pop_ok) void'(q.pop_front());
      if (ev_kind[i] == 1 && !exp_ovr) q.push_back(ev_byte[i]);
    end
  endtask

  task automatic run_seg();
    decode(wp + PAD);
    run(wp + PAD);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) rdy[wp + i] = 1'b1;
    add_level(1'b1, n);
  endtask

  task automatic check_popped(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, popped.size(), exp.size());
    for (int k = 0; k < exp.size(); k++)
      check(name, (k < popped.size()) ? popped[k] : 8'hxx, exp[k]);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valid"}, rx_valid, 1'b0);
    check({name, "_data"}, rx_data, 8'h00);
    check({name, "_ferr"}, frame_err, 1'b0);
    check({name, "_ovr"}, overrun, 1'b0);
    check({name, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    rst = 1'b0; uart_rx = 1'b1; rx_ready = 1'b0;
    #1;
    check_idle_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q.delete();

    // Single byte, then a one-cycle pop.
    seg_clear(); add_level(1'b1, 5); add_frame(8'h39, 1'b1); add_level(1'b1, 20);
    rdy[110] = 1'b1;
    run_seg();
    check("s1_first_valid", first_valid, 103);
    check("s1_busy_cycles", n_busy, 95);
    check("s1_ferr", n_ferr, 0);
    check("s1_ovr", n_ovr, 0);
    check_popped("s1_pop", '{8'h39});

    // Four back-to-back bytes fill the FIFO, then drain.
    seg_clear(); add_level(1'b1, 5);
    add_frame(8'h7F, 1'b1); add_frame(8'h00, 1'b1); add_frame(8'hFF, 1'b1); add_frame(8'hA5, 1'b1);
    add_level(1'b1, 30); drain(8);
    run_seg();
    check("s2_ovr", n_ovr, 0);
    check_popped("s2_pop", '{8'h7F, 8'h00, 8'hFF, 8'hA5});

    // Fifth byte into a full FIFO is dropped.
    seg_clear(); add_level(1'b1, 5);
    add_frame(8'h7F, 1'b1); add_frame(8'h00, 1'b1); add_frame(8'hFF, 1'b1); add_frame(8'hA5, 1'b1);
    add_frame(8'h5A, 1'b1); add_level(1'b1, 30); drain(8);
    run_seg();
    check("s3a_ovr", n_ovr, 1);
    check_popped("s3a_pop", '{8'h7F, 8'h00, 8'hFF, 8'hA5});

    // Same, with a pop on the push cycle of the fifth byte.
    seg_clear(); add_level(1'b1, 5);
    add_frame(8'h7F, 1'b1); add_frame(8'h00, 1'b1); add_frame(8'hFF, 1'b1); add_frame(8'hA5, 1'b1);
    add_frame(8'h5A, 1'b1); add_level(1'b1, 30);
    rdy[502] = 1'b1;
    drain(8);
    run_seg();
    check("s3b_ovr", n_ovr, 0);
    check_popped("s3b_pop", '{8'h7F, 8'h00, 8'hFF, 8'hA5, 8'h5A});

    // Framing error followed by a held-low line.
    seg_clear(); add_level(1'b1, 5); add_frame(8'h55, 1'b0); add_level(1'b0, 30); add_level(1'b1, 20);
    run_seg();
    check("s4_ferr", n_ferr, 1);
    check("s4_busy_cycles", n_busy, 130);
    check("s4_first_valid", first_valid, -1);

    // Short low glitch.
    seg_clear(); add_level(1'b1, 5); add_level(1'b0, 3); add_level(1'b1, 20);
    run_seg();
    check("s5_busy_cycles", n_busy, H);
    check("s5_first_valid", first_valid, -1);
    check("s5_ferr", n_ferr, 0);
    check("s5_ovr", n_ovr, 0);

    // Reset in the middle of a frame with one byte queued.
    seg_clear(); add_level(1'b1, 5); add_frame(8'h11, 1'b1); add_level(1'b1, 20); add_frame(8'h22, 1'b1);
    decode(wp + PAD);
    run(125 + 2 + H + 4 * C + 3);
    check("s6_busy_pre", busy, 1'b1);
    check("s6_valid_pre", rx_valid, 1'b1);
    #2 rst = 1'b0; uart_rx = 1'b1;
    #1;
    check_idle_outputs("s6_rst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q.delete();
    seg_clear(); add_level(1'b1, 5); add_frame(8'hC3, 1'b1); add_level(1'b1, 20); drain(4);
    run_seg();
    check("s6_first_valid", first_valid, 103);
    check("s6_ferr", n_ferr, 0);
    check_popped("s6_pop", '{8'hC3});

    // Randomised traffic: two segments with busy and sluggish consumers.
    for (int seg = 0; seg < 2; seg++) begin
      seg_clear(); add_level(1'b1, 5);
      for (int e = 0; e < 35; e++) begin
        r = $urandom_range(0, 9);
        b = 8'($urandom);
        if (r == 0) begin
          add_level(1'b0, $urandom_range(1, H - 1)); add_level(1'b1, $urandom_range(2, 12));
        end else if (r == 1) begin
          add_frame(b, 1'b0); add_level(1'b0, $urandom_range(0, 20)); add_level(1'b1, $urandom_range(1, 10));
        end else begin
          add_frame(b, 1'b1); add_level(1'b1, $urandom_range(0, 15));
        end
      end
      for (int i = 0; i < wp; i++) rdy[i] = ($urandom_range(0, (seg == 0) ? 3 : 40) == 0);
      add_level(1'b1, 10); drain(10);
      run_seg();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
